// File: rtl/snax_alu_simd_if.sv
// Streamer and CSR-manager bundle of the SIMD ALU. The accelerator takes the slave side.
interface snax_alu_simd_if #(
  parameter int NumPE        = 4,
  parameter int DataWidth    = 64,
  parameter int RegDataWidth = 32
);
  logic [NumPE*DataWidth-1:0]   stream2acc_0_data_i;
  logic                         stream2acc_0_valid_i;
  logic                         stream2acc_0_ready_o;
  logic [NumPE*DataWidth-1:0]   stream2acc_1_data_i;
  logic                         stream2acc_1_valid_i;
  logic                         stream2acc_1_ready_o;
  logic [NumPE*2*DataWidth-1:0] acc2stream_0_data_o;
  logic                         acc2stream_0_valid_o;
  logic                         acc2stream_0_ready_i;
  logic [3*RegDataWidth-1:0]    csr_reg_set_i;
  logic                         csr_reg_set_valid_i;
  logic                         csr_reg_set_ready_o;
  logic [2*RegDataWidth-1:0]    csr_reg_ro_set_o;

  modport slave (
    input  stream2acc_0_data_i, stream2acc_0_valid_i,
    input  stream2acc_1_data_i, stream2acc_1_valid_i,
    input  acc2stream_0_ready_i, csr_reg_set_i, csr_reg_set_valid_i,
    output stream2acc_0_ready_o, stream2acc_1_ready_o,
    output acc2stream_0_data_o, acc2stream_0_valid_o,
    output csr_reg_set_ready_o, csr_reg_ro_set_o
  );

  modport master (
    output stream2acc_0_data_i, stream2acc_0_valid_i,
    output stream2acc_1_data_i, stream2acc_1_valid_i,
    output acc2stream_0_ready_i, csr_reg_set_i, csr_reg_set_valid_i,
    input  stream2acc_0_ready_o, stream2acc_1_ready_o,
    input  acc2stream_0_data_o, acc2stream_0_valid_o,
    input  csr_reg_set_ready_o, csr_reg_ro_set_o
  );
endinterface

// File: rtl/snax_alu_simd.sv
// Multi-mode SIMD ALU: per-lane ADD/SUB/MUL/XOR/MAC feeding an elastic result pipeline.
module snax_alu_lane #(
  parameter int DataWidth = 64
) (
  input  logic [DataWidth-1:0]   a,
  input  logic [DataWidth-1:0]   b,
  input  logic [2:0]             mode,
  input  logic [2*DataWidth-1:0] acc,
  output logic [2*DataWidth-1:0] res
);
  logic [2*DataWidth-1:0] za, zb, prod;
  assign za   = {{DataWidth{1'b0}}, a};
  assign zb   = {{DataWidth{1'b0}}, b};
  assign prod = za * zb;

  // Unused mode encodings fall back to ADD
  always_comb begin
    res = za + zb;
    case (mode)
      3'd1:    res = za - zb;
      3'd2:    res = prod;
      3'd3:    res = za ^ zb;
      3'd4:    res = acc + prod;
      default: res = za + zb;
    endcase
  end
endmodule

module snax_alu_simd #(
  parameter int NumPE        = 4,
  parameter int DataWidth    = 64,
  parameter int RegDataWidth = 32,
  parameter int PipeDepth    = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  snax_alu_simd_if.slave bus
);
  localparam int ResW = 2*DataWidth;
  localparam int Last = PipeDepth-1;
  localparam logic [2:0] ModeMac = 3'd4;
  localparam logic [RegDataWidth-1:0] One = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic [NumPE-1:0][DataWidth-1:0] op_a, op_b;
  logic [NumPE-1:0][ResW-1:0]      res, acc_q;
  logic [PipeDepth-1:0]            vld_pipe, adv, ld_v;
  logic [PipeDepth-1:0][NumPE-1:0][ResW-1:0] dat_pipe, ld_d;
  logic [2:0]              mode_q;
  logic [RegDataWidth-1:0] len_q, in_cnt_q, out_cnt_q, perf_q;
  logic [RegDataWidth-1:0] cfg_mode, cfg_len, cfg_start;
  logic csr_rdy, cfg_fire, start, st0_ok, in_fire, in_last, load0;
  logic out_fire, out_last, is_mac, busy, unused_csr;

  assign op_a      = bus.stream2acc_0_data_i;
  assign op_b      = bus.stream2acc_1_data_i;
  assign cfg_mode  = bus.csr_reg_set_i[0 +: RegDataWidth];
  assign cfg_len   = bus.csr_reg_set_i[RegDataWidth +: RegDataWidth];
  assign cfg_start = bus.csr_reg_set_i[2*RegDataWidth +: RegDataWidth];
  assign unused_csr = ^{cfg_mode[RegDataWidth-1:3], cfg_start[RegDataWidth-1:1]};

  assign busy     = (state_q != IDLE);
  assign csr_rdy  = !rst_i && (state_q == IDLE);
  assign cfg_fire = bus.csr_reg_set_valid_i && csr_rdy;
  assign start    = cfg_start[0];
  assign is_mac   = (mode_q == ModeMac);
  assign in_fire  = !rst_i && (state_q == RUN) && (in_cnt_q < len_q) &&
                    bus.stream2acc_0_valid_i && bus.stream2acc_1_valid_i && st0_ok;
  assign in_last  = (in_cnt_q == len_q - One);
  // MAC beats only enter the pipeline once, carrying the final sum
  assign load0    = in_fire && (!is_mac || in_last);
  assign out_fire = vld_pipe[Last] && bus.acc2stream_0_ready_i;
  assign out_last = is_mac || (out_cnt_q == len_q - One);

  for (genvar l = 0; l < NumPE; l++) begin : g_lane
    snax_alu_lane #(.DataWidth(DataWidth)) u_lane (
      .a(op_a[l]), .b(op_b[l]), .mode(mode_q), .acc(acc_q[l]), .res(res[l])
    );
  end

  // Ready ripples back from the output: a stage moves when everything ahead can take it
  always_comb begin
    logic ok;
    adv = '0;
    ok  = bus.acc2stream_0_ready_i;
    for (int s = PipeDepth-1; s >= 0; s--) begin
      adv[s] = vld_pipe[s] && ok;
      ok     = !vld_pipe[s] || adv[s];
    end
    st0_ok = ok;
  end

  always_comb begin
    ld_v    = '0;
    ld_d    = '0;
    ld_v[0] = load0;
    ld_d[0] = res;
    for (int s = 1; s < PipeDepth; s++) begin
      ld_v[s] = adv[s-1];
      ld_d[s] = dat_pipe[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      for (int s = 0; s < PipeDepth; s++) begin
        if (!vld_pipe[s] || adv[s]) begin
          vld_pipe[s] <= ld_v[s];
          if (ld_v[s]) dat_pipe[s] <= ld_d[s];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_fire && start && (cfg_len != '0)) state_d = RUN;
      RUN:     if (in_fire && in_last) state_d = DRAIN;
      DRAIN:   if (out_fire && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      perf_q    <= '0;
      acc_q     <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_fire) begin
        mode_q <= cfg_mode[2:0];
        len_q  <= cfg_len;
        if (start) begin
          in_cnt_q  <= '0;
          out_cnt_q <= '0;
          perf_q    <= '0;
          acc_q     <= '0;
        end
      end else begin
        if (in_fire)           in_cnt_q  <= in_cnt_q + One;
        if (in_fire && is_mac) acc_q     <= res;
        if (out_fire)          out_cnt_q <= out_cnt_q + One;
        if (busy && (perf_q != '1)) perf_q <= perf_q + One;
      end
    end
  end

  assign bus.stream2acc_0_ready_o = in_fire;
  assign bus.stream2acc_1_ready_o = in_fire;
  assign bus.acc2stream_0_valid_o = !rst_i && vld_pipe[Last];
  assign bus.acc2stream_0_data_o  = rst_i ? '0 : dat_pipe[Last];
  assign bus.csr_reg_set_ready_o  = csr_rdy;
  assign bus.csr_reg_ro_set_o     = rst_i ? '0 : {perf_q, {(RegDataWidth-1){1'b0}}, busy};
endmodule

// File: tb/tb_snax_alu_simd.sv
// Directed bench for snax_alu_simd: scoreboard of expected beats checked on output handshakes.
module tb_snax_alu_simd;
  localparam int NP = 4, DW = 64, RW = 32, D = 2;
  localparam int AW = NP*DW, OW = NP*2*DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snax_alu_simd_if #(.NumPE(NP), .DataWidth(DW), .RegDataWidth(RW)) bus();
  snax_alu_simd #(.NumPE(NP), .DataWidth(DW), .RegDataWidth(RW), .PipeDepth(D)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  int tests = 0, fails = 0, cyc = 0, in_hs = 0, outs = 0, rdy_mode = 0;
  int in_cyc[$], out_cyc[$];
  logic [OW-1:0] exp_q[$];
  logic          held_v = 1'b0;
  logic [OW-1:0] held_d;
  logic [2*DW-1:0] macc [NP];

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*DW-1:0] ref_lane(input int mode, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] x, y;
    x = {{DW{1'b0}}, a};
    y = {{DW{1'b0}}, b};
    case (mode)
      1:       return x - y;
      2:       return x * y;
      3:       return x ^ y;
      default: return x + y;
    endcase
  endfunction

  function automatic logic [OW-1:0] ref_beat(input int mode, input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [OW-1:0] r;
    for (int i = 0; i < NP; i++) r[i*2*DW +: 2*DW] = ref_lane(mode, a[i*DW +: DW], b[i*DW +: DW]);
    return r;
  endfunction

  function automatic logic [AW-1:0] rnd();
    logic [AW-1:0] r;
    for (int i = 0; i < AW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output ready: 0 = held low, 1 = held high, 2 = toggling every cycle
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.acc2stream_0_ready_i = 1'b0;
      1:       bus.acc2stream_0_ready_i = 1'b1;
      default: bus.acc2stream_0_ready_i = ~bus.acc2stream_0_ready_i;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      chk("rdy_coincide", bus.stream2acc_0_ready_o, bus.stream2acc_1_ready_o);
      if (bus.csr_reg_set_valid_i && bus.csr_reg_set_ready_o)
        chk("cfg_only_idle", bus.csr_reg_ro_set_o[0], 1'b0);
      if (bus.stream2acc_0_valid_i && bus.stream2acc_0_ready_o) begin
        in_hs++;
        in_cyc.push_back(cyc);
      end
      if (held_v) begin
        chk("stall_valid", bus.acc2stream_0_valid_o, 1'b1);
        chk("stall_data", bus.acc2stream_0_data_o, held_d);
      end
      if (bus.acc2stream_0_valid_o && bus.acc2stream_0_ready_i) begin
        outs++;
        out_cyc.push_back(cyc);
        chk("sb_has_entry", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("sb_data", bus.acc2stream_0_data_o, exp_q.pop_front());
      end
      held_v = bus.acc2stream_0_valid_o && !bus.acc2stream_0_ready_i;
      held_d = bus.acc2stream_0_data_o;
    end
  end

  task automatic cfg(input int mode, input int len, input bit start);
    bit seen = 1'b0;
    bus.csr_reg_set_i       = {32'(start), 32'(len), 32'(mode)};
    bus.csr_reg_set_valid_i = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.csr_reg_set_ready_o) begin seen = 1'b1; break; end
    end
    chk("cfg_handshake", seen, 1'b1);
    @(posedge clk); #1;
    bus.csr_reg_set_valid_i = 1'b0;
  endtask

  task automatic send_beat(input logic [AW-1:0] a, input logic [AW-1:0] b, input bit push, input int mode);
    bit seen = 1'b0;
    bus.stream2acc_0_data_i  = a;
    bus.stream2acc_1_data_i  = b;
    bus.stream2acc_0_valid_i = 1'b1;
    bus.stream2acc_1_valid_i = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.stream2acc_0_ready_o) begin seen = 1'b1; break; end
    end
    chk("in_handshake", seen, 1'b1);
    if (push) exp_q.push_back(ref_beat(mode, a, b));
    @(posedge clk); #1;
    bus.stream2acc_0_valid_i = 1'b0;
    bus.stream2acc_1_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a, b;
    logic [RW-1:0] perf0;
    int n0;
    bus.stream2acc_0_data_i = '0; bus.stream2acc_0_valid_i = 1'b0;
    bus.stream2acc_1_data_i = '0; bus.stream2acc_1_valid_i = 1'b0;
    bus.csr_reg_set_i = '0; bus.csr_reg_set_valid_i = 1'b0;
    bus.acc2stream_0_ready_i = 1'b0;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {bus.acc2stream_0_valid_o, bus.stream2acc_0_ready_o, bus.csr_reg_set_ready_o}, 3'b000);
    chk("rst_ro", bus.csr_reg_ro_set_o, '0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("idle_csr_rdy", bus.csr_reg_set_ready_o, 1'b1);
    chk("idle_ro", bus.csr_reg_ro_set_o, '0);
    chk("idle_out", {bus.acc2stream_0_valid_o, bus.stream2acc_0_ready_o}, 2'b00);
    @(posedge clk); #1;

    // ADD back-to-back with carry out of every lane
    rdy_mode = 1;
    @(posedge clk); #1;
    in_cyc.delete(); out_cyc.delete(); n0 = outs;
    cfg(0, 3, 1'b1);
    a = '1;
    b = {NP{64'd1}};
    repeat (3) send_beat(a, b, 1'b1, 0);
    drain();
    chk("add_nout", outs - n0, 3);
    chk("add_latency", out_cyc[0] - in_cyc[0], D);
    chk("add_in_b2b", in_cyc[2] - in_cyc[0], 2);
    chk("add_out_b2b", out_cyc[2] - out_cyc[0], 2);
    @(negedge clk);
    chk("add_busy_done", bus.csr_reg_ro_set_o[0], 1'b0);
    @(posedge clk); #1;

    // SUB then MUL under toggling output ready
    rdy_mode = 2;
    n0 = outs;
    cfg(1, 3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      a = rnd(); b = rnd();
      a[0 +: DW] = 64'd3; b[0 +: DW] = 64'd5;
      send_beat(a, b, 1'b1, 1);
    end
    drain();
    chk("sub_nout", outs - n0, 3);
    n0 = outs;
    cfg(2, 3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      a = rnd(); b = rnd();
      a[0 +: DW] = '1; b[0 +: DW] = '1;
      send_beat(a, b, 1'b1, 2);
    end
    drain();
    chk("mul_nout", outs - n0, 3);

    // MAC: one output beat carrying the per-lane sum of products
    rdy_mode = 1;
    @(posedge clk); #1;
    n0 = outs;
    for (int i = 0; i < NP; i++) macc[i] = '0;
    cfg(4, 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      a = rnd(); b = rnd();
      a[0 +: DW] = 64'(2*k + 1); b[0 +: DW] = 64'(2*k + 2);
      for (int i = 0; i < NP; i++)
        macc[i] = macc[i] + ({{DW{1'b0}}, a[i*DW +: DW]} * {{DW{1'b0}}, b[i*DW +: DW]});
      send_beat(a, b, 1'b0, 4);
    end
    exp_q.push_back({macc[3], macc[2], macc[1], macc[0]});
    drain();
    chk("mac_nout", outs - n0, 1);
    @(negedge clk);
    chk("mac_perf_min", bus.csr_reg_ro_set_o[2*RW-1:RW] >= RW'(4 + D), 1'b1);
    perf0 = bus.csr_reg_ro_set_o[2*RW-1:RW];
    repeat (3) @(negedge clk);
    chk("perf_hold_idle", bus.csr_reg_ro_set_o[2*RW-1:RW], perf0);
    @(posedge clk); #1;

    // Valid skew: B arrives three cycles after A
    cfg(0, 1, 1'b1);
    n0 = in_hs;
    a = rnd(); b = rnd();
    bus.stream2acc_0_data_i = a; bus.stream2acc_1_data_i = b;
    bus.stream2acc_0_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("skew_no_rdy", {bus.stream2acc_0_ready_o, bus.stream2acc_1_ready_o}, 2'b00);
      @(posedge clk); #1;
    end
    bus.stream2acc_1_valid_i = 1'b1;
    @(negedge clk);
    chk("skew_both_rdy", {bus.stream2acc_0_ready_o, bus.stream2acc_1_ready_o}, 2'b11);
    exp_q.push_back(ref_beat(0, a, b));
    @(posedge clk); #1;
    bus.stream2acc_0_valid_i = 1'b0; bus.stream2acc_1_valid_i = 1'b0;
    chk("skew_in_cnt", in_hs - n0, 1);
    drain();

    // LEN=0 starts nothing
    n0 = outs;
    cfg(0, 0, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("len0_busy", bus.csr_reg_ro_set_o[0], 1'b0);
    end
    chk("len0_nout", outs - n0, 0);
    @(posedge clk); #1;

    // MODE 6 behaves as ADD; a config offered mid-job waits for IDLE
    cfg(6, 1, 1'b1);
    bus.csr_reg_set_i = {32'd0, 32'd7, 32'd0};
    bus.csr_reg_set_valid_i = 1'b1;
    @(negedge clk);
    chk("cfg_blocked_busy", bus.csr_reg_set_ready_o, 1'b0);
    @(posedge clk); #1;
    a = rnd(); b = rnd();
    send_beat(a, b, 1'b1, 6);
    drain();
    n0 = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.csr_reg_set_ready_o) begin n0 = 1; break; end
    end
    chk("cfg_accept_idle", n0, 1);
    @(posedge clk); #1;
    bus.csr_reg_set_valid_i = 1'b0;
    @(negedge clk);
    chk("cfg_nostart_idle", bus.csr_reg_ro_set_o[0], 1'b0);
    @(posedge clk); #1;

    // Reset mid-job discards in-flight beats
    rdy_mode = 0;
    n0 = outs;
    cfg(0, 5, 1'b1);
    send_beat(rnd(), rnd(), 1'b0, 0);
    send_beat(rnd(), rnd(), 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctrl", {bus.acc2stream_0_valid_o, bus.stream2acc_0_ready_o,
                        bus.stream2acc_1_ready_o, bus.csr_reg_set_ready_o}, 4'b0000);
    chk("midrst_data", bus.acc2stream_0_data_o, '0);
    chk("midrst_ro", bus.csr_reg_ro_set_o, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 1;
    @(negedge clk);
    chk("postrst_idle", {bus.csr_reg_set_ready_o, bus.csr_reg_ro_set_o[0], bus.acc2stream_0_valid_o}, 3'b100);
    @(posedge clk); #1;
    cfg(0, 1, 1'b1);
    send_beat(rnd(), rnd(), 1'b1, 0);
    drain();
    chk("postrst_nout", outs - n0, 1);

    chk("sb_final_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
